// File: rtl/divi_restoring.sv
// Sequential signed restoring divider: one quotient bit per clock on magnitudes,
// with sign fix-up and divide-by-zero / overflow flags, start/fin_div handshake.
module divi_restoring #(
  parameter int size = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   start,
  input  logic signed [size-1:0] A,
  input  logic signed [size-1:0] B,
  output logic signed [size-1:0] Q,
  output logic signed [size-1:0] R,
  output logic                   fin_div,
  output logic                   busy,
  output logic                   div_zero,
  output logic                   ovf
);

  localparam int CW = $clog2(size) + 1;
  localparam logic signed [size-1:0] MIN_VAL = {1'b1, {(size-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FIX, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic signed [size-1:0] a_q, a_d, b_q, b_d;
  logic [size-1:0]        dvd_q, dvd_d, dsr_q, dsr_d, rem_q, rem_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [size-1:0] quo_q, quo_d, rmd_q, rmd_d;
  logic                   fin_q, fin_d, busy_q, busy_d, dz_q, dz_d, ovf_q, ovf_d;
  logic [size:0]          rem_sh, trial;

  // Magnitude as unsigned; the most negative value maps to 2^(size-1).
  function automatic logic [size-1:0] abs_val(input logic signed [size-1:0] v);
    abs_val = v[size-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [size-1:0] cond_neg(input logic neg, input logic [size-1:0] v);
    cond_neg = neg ? (~v + 1'b1) : v;
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    fin_d   = fin_q;
    busy_d  = busy_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    rem_sh  = {rem_q, dvd_q[size-1]};
    trial   = rem_sh - {1'b0, dsr_q};
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        dvd_d   = abs_val(a_q);
        dsr_d   = abs_val(b_q);
        rem_d   = '0;
        cnt_d   = '0;
        // A zero divisor has nothing to iterate; FIX commits the fixed -1/A result.
        state_d = (b_q == '0) ? S_FIX : S_ITER;
      end
      S_ITER: begin
        // Dividend shifts out at the top while quotient bits fill in at the bottom.
        dvd_d = {dvd_q[size-2:0], ~trial[size]};
        rem_d = trial[size] ? rem_sh[size-1:0] : trial[size-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(size - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        busy_d  = 1'b0;
        fin_d   = 1'b1;
        state_d = S_DONE;
        if (b_q == '0) begin
          quo_d = '1;
          rmd_d = a_q;
          dz_d  = 1'b1;
          ovf_d = 1'b0;
        end else begin
          quo_d = $signed(cond_neg(a_q[size-1] ^ b_q[size-1], dvd_q));
          rmd_d = $signed(cond_neg(a_q[size-1], rem_q));
          dz_d  = 1'b0;
          ovf_d = (a_q == MIN_VAL) && (b_q == '1);
        end
      end
      S_DONE: begin
        if (!start) begin
          fin_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge CLK) begin
    a_q   <= a_d;
    b_q   <= b_d;
    dvd_q <= dvd_d;
    dsr_q <= dsr_d;
    rem_q <= rem_d;
  end

  assign Q        = quo_q;
  assign R        = rmd_q;
  assign fin_div  = fin_q;
  assign busy     = busy_q;
  assign div_zero = dz_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_divi_restoring.sv
// Bench for divi_restoring: directed and randomized signed divisions checked against
// an arithmetic reference (integer / and %), plus latency, handshake and reset checks.
module tb_divi_restoring;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              start = 1'b0;
  logic signed [7:0] A = '0;
  logic signed [7:0] B = '0;
  logic signed [7:0] Q, R;
  logic              fin_div, busy, div_zero, ovf;

  int n_vec = 0;
  int n_err = 0;

  divi_restoring #(.size(8)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .A(A), .B(B),
    .Q(Q), .R(R), .fin_div(fin_div), .busy(busy), .div_zero(div_zero), .ovf(ovf)
  );

  always #5 CLK = ~CLK;

  function automatic void model(input logic signed [7:0] a, input logic signed [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic dz, output logic ov, output int lat);
    int ai, bi;
    ai = a;
    bi = b;
    if (bi == 0) begin
      q = 8'hFF; r = a; dz = 1'b1; ov = 1'b0; lat = 2;
    end else begin
      q = 8'(ai / bi); r = 8'(ai % bi); dz = 1'b0;
      ov = (ai == -128) && (bi == -1); lat = 10;
    end
  endfunction

  // Runs one operation from IDLE; lat = edges after the accepting edge until fin_div, -1 on timeout.
  task automatic do_op(input logic signed [7:0] a, input logic signed [7:0] b,
                       input bit hold, input bit toggle, output int lat);
    @(negedge CLK); start = 1'b0;
    @(posedge CLK);
    @(negedge CLK); A = a; B = b; start = 1'b1;
    @(posedge CLK); #1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (!hold) start = 1'b0;
      if (toggle) begin A = 8'($urandom); B = 8'($urandom); end
      @(posedge CLK); #1;
      if (fin_div) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge CLK); RESET = 1'b1; start = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    n_vec++; if (Q !== 8'sd0) begin n_err++; $display("FAIL reset_Q got %h want 00", Q); end
    n_vec++; if (R !== 8'sd0) begin n_err++; $display("FAIL reset_R got %h want 00", R); end
    n_vec++; if ({fin_div, busy, div_zero, ovf} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags got fin/busy/dz/ovf=%b want 0000", {fin_div, busy, div_zero, ovf});
    end
    @(negedge CLK); RESET = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    do_op(8'sd45, 8'sd7, 1'b1, 1'b0, lat);
    n_vec++; if (lat !== 10) begin n_err++; $display("FAIL basic_latency got %0d want 10", lat); end
    n_vec++; if (Q !== 8'sd6) begin n_err++; $display("FAIL basic_Q got %0d want 6", Q); end
    n_vec++; if (R !== 8'sd3) begin n_err++; $display("FAIL basic_R got %0d want 3", R); end
    n_vec++; if ({busy, div_zero, ovf} !== 3'b000) begin
      n_err++; $display("FAIL basic_flags got busy/dz/ovf=%b want 000", {busy, div_zero, ovf});
    end
    repeat (3) @(posedge CLK); #1;
    n_vec++; if (fin_div !== 1'b1) begin n_err++; $display("FAIL done_hold got fin=%b want 1", fin_div); end
    @(negedge CLK); start = 1'b0;
    @(posedge CLK); #1;
    n_vec++; if (fin_div !== 1'b0) begin n_err++; $display("FAIL done_release got fin=%b want 0", fin_div); end
    n_vec++; if (Q !== 8'sd6 || R !== 8'sd3) begin
      n_err++; $display("FAIL idle_hold got Q=%0d R=%0d want 6 3", Q, R);
    end
  endtask

  task automatic test_directed();
    logic signed [7:0] ta [9] = '{8'sd45, -8'sd45, 8'sd45, -8'sd45, 8'sd5, -8'sd128, -8'sd128, 8'sd100, 8'sd127};
    logic signed [7:0] tb [9] = '{8'sd7,  8'sd7,  -8'sd7, -8'sd7,  8'sd9, 8'sd1,     -8'sd1,    8'sd0,   -8'sd128};
    logic [7:0] eq, er;
    logic edz, eov;
    int elat, lat;
    for (int i = 0; i < 9; i++) begin
      model(ta[i], tb[i], eq, er, edz, eov, elat);
      do_op(ta[i], tb[i], 1'b0, 1'b0, lat);
      n_vec++; if (lat !== elat) begin
        n_err++; $display("FAIL dir_latency %0d/%0d got %0d want %0d", ta[i], tb[i], lat, elat);
      end
      n_vec++; if (Q !== eq || R !== er) begin
        n_err++; $display("FAIL dir_QR %0d/%0d got Q=%h R=%h want Q=%h R=%h", ta[i], tb[i], Q, R, eq, er);
      end
      n_vec++; if (div_zero !== edz || ovf !== eov) begin
        n_err++; $display("FAIL dir_flags %0d/%0d got dz=%b ovf=%b want dz=%b ovf=%b", ta[i], tb[i], div_zero, ovf, edz, eov);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge CLK); start = 1'b0;
    @(posedge CLK);
    @(negedge CLK); A = 8'sd45; B = 8'sd7; start = 1'b1;
    @(posedge CLK);
    @(negedge CLK); start = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got %b want 1", busy); end
    @(negedge CLK); RESET = 1'b1;
    @(posedge CLK); #1;
    n_vec++; if ({Q, R} !== 16'h0000 || {fin_div, busy, div_zero, ovf} !== 4'b0000) begin
      n_err++; $display("FAIL mid_reset got Q=%h R=%h flags=%b want 00 00 0000", Q, R, {fin_div, busy, div_zero, ovf});
    end
    @(negedge CLK); RESET = 1'b0;
    repeat (12) @(posedge CLK);
    #1;
    n_vec++; if (fin_div !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_discard got fin=%b busy=%b want 0 0", fin_div, busy);
    end
    do_op(8'sd45, 8'sd7, 1'b0, 1'b0, lat);
    n_vec++; if (lat !== 10 || Q !== 8'sd6 || R !== 8'sd3) begin
      n_err++; $display("FAIL mid_rerun got lat=%0d Q=%0d R=%0d want 10 6 3", lat, Q, R);
    end
  endtask

  task automatic test_no_restart();
    logic [7:0] eq, er;
    logic edz, eov;
    int elat, lat;
    logic signed [7:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom);
      b = (i == 0) ? 8'sd0 : 8'($urandom_range(1, 255));
      model(a, b, eq, er, edz, eov, elat);
      do_op(a, b, 1'b1, 1'b1, lat);
      repeat (4) begin
        @(negedge CLK); A = 8'($urandom); B = 8'($urandom);
        @(posedge CLK);
      end
      #1;
      n_vec++; if (lat !== elat || fin_div !== 1'b1 || busy !== 1'b0) begin
        n_err++; $display("FAIL norestart_ctl %0d/%0d got lat=%0d fin=%b busy=%b want %0d 1 0", a, b, lat, fin_div, busy, elat);
      end
      n_vec++; if (Q !== eq || R !== er || div_zero !== edz || ovf !== eov) begin
        n_err++; $display("FAIL norestart_res %0d/%0d got Q=%h R=%h dz=%b ovf=%b want %h %h %b %b", a, b, Q, R, div_zero, ovf, eq, er, edz, eov);
      end
    end
  endtask

  task automatic test_random();
    bit a_bin [16];
    bit b_bin [16];
    int hits, n, lat, elat;
    logic [7:0] eq, er;
    logic edz, eov;
    logic signed [7:0] a, b;
    n = 0;
    hits = 0;
    while ((n < 150 || hits < 29) && n < 1500) begin
      a = 8'($urandom);
      b = 8'($urandom_range(1, 255));
      if ($urandom_range(0, 15) == 0) a = -8'sd128;
      model(a, b, eq, er, edz, eov, elat);
      do_op(a, b, 1'b0, 1'b0, lat);
      n_vec++; if (lat !== elat || Q !== eq || R !== er || div_zero !== edz || ovf !== eov) begin
        n_err++; $display("FAIL rand %0d/%0d got lat=%0d Q=%h R=%h dz=%b ovf=%b want %0d %h %h %b %b", a, b, lat, Q, R, div_zero, ovf, elat, eq, er, edz, eov);
      end
      a_bin[a[7:4]] = 1'b1;
      b_bin[b[7:4]] = 1'b1;
      hits = 0;
      for (int k = 0; k < 16; k++) hits += int'(a_bin[k]) + int'(b_bin[k]);
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_reset_mid();
    test_no_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
